// File: rtl/slot_pkg.sv
// -----------------------------------------------------------------------------
// slot_pkg
// Shared definitions for the spin trigger block: FSM state encoding, the
// spin counter width, the default timing parameters and a helper that sizes
// down-counters.
// No ports (package).
// -----------------------------------------------------------------------------
package slot_pkg;

    localparam int SPIN_COUNT_W      = 8;
    localparam int DEF_CLK_DIV       = 100000;
    localparam int DEF_LOCKOUT_TICKS = 50;
    localparam int DEF_HOLD_TICKS    = 100;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_LOCKOUT = 2'd2,
        ST_RELEASE = 2'd3
    } spin_state_e;

    // Bits needed to hold the values 0..n-1; never less than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/spin_trigger_if.sv
// -----------------------------------------------------------------------------
// spin_trigger_if
// Button / reel-controller signals of the spin trigger.
//   db_in      : debounced spin button level (1 = pressed), async to clk
//   spin_ack   : reel controller accepts the pending spin request
//   spin_req   : registered spin request towards the reel controller
//   busy       : trigger FSM is not idle
//   spin_count : number of completed spin handshakes (wraps)
// Modports: master = button/reel side, slave = spin_trigger.
// -----------------------------------------------------------------------------
interface spin_trigger_if;

    logic                              db_in;
    logic                              spin_ack;
    logic                              spin_req;
    logic                              busy;
    logic [slot_pkg::SPIN_COUNT_W-1:0] spin_count;

    modport master (
        output db_in,
        output spin_ack,
        input  spin_req,
        input  busy,
        input  spin_count
    );

    modport slave (
        input  db_in,
        input  spin_ack,
        output spin_req,
        output busy,
        output spin_count
    );

endinterface

// File: rtl/tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
// Free-running divider: counts 0..CLK_DIV-1 and raises tick for the single
// cycle in which the count equals CLK_DIV-1.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   tick  : one-cycle pulse every CLK_DIV cycles (registered)
// -----------------------------------------------------------------------------
module tick_gen
    import slot_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int           CNT_W    = cnt_width(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             tick_q;
    logic             tick_d;

    // Next count with wrap; tick is precomputed so the registered pulse lines
    // up exactly with the cycle where the count sits at its last value.
    always_comb begin
        cnt_d = '0;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        tick_d = (cnt_d == CNT_LAST);
    end

    // Divider state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/spin_trigger.sv
// -----------------------------------------------------------------------------
// spin_trigger
// Turns a debounced spin button into a spin request / acknowledge handshake
// with a post-spin lockout and a wait-for-release phase.
//   clk   : system clock, all state on rising edge
//   rst_n : asynchronous active-low reset
//   bus   : spin_trigger_if.slave (db_in, spin_ack in; spin_req, busy,
//           spin_count out)
// Optional feature: define SPIN_AUTOREPEAT_EN to let a held button re-issue
// a spin after HOLD_TICKS ticks in RELEASE. Without it RELEASE only waits
// for the button to be let go and no hold counter exists.
// -----------------------------------------------------------------------------
module spin_trigger
    import slot_pkg::*;
#(
    parameter int CLK_DIV       = DEF_CLK_DIV,
    parameter int LOCKOUT_TICKS = DEF_LOCKOUT_TICKS,
    parameter int HOLD_TICKS    = DEF_HOLD_TICKS
) (
    input logic           clk,
    input logic           rst_n,
    spin_trigger_if.slave bus
);

    localparam logic [1:0] S_IDLE    = ST_IDLE;
    localparam logic [1:0] S_REQ     = ST_REQ;
    localparam logic [1:0] S_LOCKOUT = ST_LOCKOUT;
    localparam logic [1:0] S_RELEASE = ST_RELEASE;

    localparam int                LOCK_W    = cnt_width(LOCKOUT_TICKS);
    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCKOUT_TICKS - 1);

    logic sync1_q;
    logic sync2_q;
    logic sync3_q;
    logic vld1_q;
    logic vld2_q;
    logic armed_q;
    logic armed_s;
    logic rise_s;
    logic tick_s;

    logic [1:0]              state_q;
    logic [1:0]              state_d;
    logic [LOCK_W-1:0]       lock_cnt_q;
    logic [LOCK_W-1:0]       lock_cnt_d;
    logic [SPIN_COUNT_W-1:0] count_q;
    logic [SPIN_COUNT_W-1:0] count_d;
    logic                    spin_req_q;
    logic                    busy_q;

`ifdef SPIN_AUTOREPEAT_EN
    localparam int                HOLD_W    = cnt_width(HOLD_TICKS);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);

    logic [HOLD_W-1:0] hold_cnt_q;
    logic [HOLD_W-1:0] hold_cnt_d;
`endif

    tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick_s)
    );

    // The vld chain marks when sync2 reflects a real sample of db_in. A
    // press only counts once a genuine low level has been seen, so a button
    // already held through reset cannot fire a spin.
    assign armed_s = armed_q | (vld2_q & ~sync2_q);
    assign rise_s  = sync2_q & ~sync3_q & armed_q;

    // Button synchronizer, edge-detect delay flop and arming logic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
            vld1_q  <= 1'b0;
            vld2_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            sync1_q <= bus.db_in;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            vld1_q  <= 1'b1;
            vld2_q  <= vld1_q;
            armed_q <= armed_s;
        end
    end

    // FSM next-state, lockout/hold counting and handshake counting.
    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        count_d    = count_q;
`ifdef SPIN_AUTOREPEAT_EN
        hold_cnt_d = hold_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (rise_s) begin
                    state_d = S_REQ;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                if (bus.spin_ack) begin
                    state_d = S_LOCKOUT;
                    count_d = count_q + SPIN_COUNT_W'(1);
                end else begin
                    state_d = S_REQ;
                end
            end
            S_LOCKOUT: begin
                if (tick_s) begin
                    if (lock_cnt_q == LOCK_LAST) begin
                        if (sync2_q) begin
                            state_d = S_RELEASE;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        lock_cnt_d = lock_cnt_q + LOCK_W'(1);
                    end
                end else begin
                    state_d = S_LOCKOUT;
                end
            end
            S_RELEASE: begin
                if (!sync2_q) begin
                    state_d = S_IDLE;
                end else begin
`ifdef SPIN_AUTOREPEAT_EN
                    if (tick_s) begin
                        if (hold_cnt_q == HOLD_LAST) begin
                            state_d = S_REQ;
                        end else begin
                            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                        end
                    end else begin
                        state_d = S_RELEASE;
                    end
`else
                    state_d = S_RELEASE;
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM state and output registers; tick counters restart on every state
    // entry, and the outputs are derived from the next state so they change
    // on the same edge as the state itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            lock_cnt_q <= '0;
            count_q    <= '0;
            spin_req_q <= 1'b0;
            busy_q     <= 1'b0;
`ifdef SPIN_AUTOREPEAT_EN
            hold_cnt_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            if (state_d != state_q) begin
                lock_cnt_q <= '0;
`ifdef SPIN_AUTOREPEAT_EN
                hold_cnt_q <= '0;
`endif
            end else begin
                lock_cnt_q <= lock_cnt_d;
`ifdef SPIN_AUTOREPEAT_EN
                hold_cnt_q <= hold_cnt_d;
`endif
            end
            count_q    <= count_d;
            spin_req_q <= (state_d == S_REQ);
            busy_q     <= (state_d != S_IDLE);
        end
    end

    assign bus.spin_req   = spin_req_q;
    assign bus.busy       = busy_q;
    assign bus.spin_count = count_q;

endmodule

// File: tb/tb_spin_trigger.sv
// -----------------------------------------------------------------------------
// tb_spin_trigger
// Scoreboard bench for spin_trigger (CLK_DIV=4, LOCKOUT_TICKS=2,
// HOLD_TICKS=3). Stimulus pushes the expected spin_count of every spin it
// expects; a monitor pops one entry per observed handshake.
// -----------------------------------------------------------------------------
module tb_spin_trigger;
    import slot_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    spin_trigger_if bus ();

    spin_trigger #(
        .CLK_DIV       (4),
        .LOCKOUT_TICKS (2),
        .HOLD_TICKS    (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int         checks    = 0;
    int         failures  = 0;
    int         exp_count = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Reference model: every accepted press completes one spin, count mod 256.
    task automatic expect_spin();
        exp_count = (exp_count + 1) % 256;
        exp_q.push_back(8'(exp_count));
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 60; i++) begin
            if (!bus.busy) break;
            @(negedge clk);
        end
        check({tag, "_idle_timeout"}, bus.busy, 1'b0);
    endtask

    // Press from idle (called just after a falling edge): spin_req must be low
    // after two rising edges and high after the third.
    task automatic press_chk(input string tag);
        bus.db_in = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check({tag, "_req_early"}, bus.spin_req, 1'b0);
        check({tag, "_busy_early"}, bus.busy, 1'b0);
        @(negedge clk);
        check({tag, "_req_rise"}, bus.spin_req, 1'b1);
        check({tag, "_busy_rise"}, bus.busy, 1'b1);
    endtask

    // Monitor: every handshake must be expected and leave the expected count.
    always begin
        @(negedge clk);
        #2;
        if (rst_n && bus.spin_req && bus.spin_ack) begin
            check("spin_expected", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) begin
                mon_exp = exp_q.pop_front();
                @(posedge clk);
                #1;
                check("spin_count", bus.spin_count, mon_exp);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi;
        int n;
        int prev;
        int t[3];
        int d;

        bus.db_in    = 1'b0;
        bus.spin_ack = 1'b0;
        cyc(3);
        check("rst_req", bus.spin_req, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_count", bus.spin_count, 8'd0);
        rst_n = 1'b1;
        cyc(5);

        // Ack tied high: one-cycle request, busy until button released.
        bus.spin_ack = 1'b1;
        expect_spin();
        press_chk("t1");
        @(negedge clk);
        check("t1_req_one_cycle", bus.spin_req, 1'b0);
        check("t1_busy_after", bus.busy, 1'b1);
        check("t1_count", bus.spin_count, 8'(exp_count));
        cyc(10);
        check("t1_busy_held", bus.busy, 1'b1);
        bus.db_in = 1'b0;
        wait_idle("t1");
        bus.spin_ack = 1'b0;
        cyc(2);

        // Ack withheld for 20 cycles, then pulsed.
        expect_spin();
        press_chk("t2");
        bus.db_in = 1'b0;
        hi = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.spin_req) hi++;
        end
        check("t2_req_held", hi, 20);
        bus.spin_ack = 1'b1;
        @(negedge clk);
        bus.spin_ack = 1'b0;
        check("t2_req_drop", bus.spin_req, 1'b0);
        check("t2_count", bus.spin_count, 8'(exp_count));
        wait_idle("t2");
        cyc(2);

        // Re-press during lockout must be ignored.
        bus.spin_ack = 1'b1;
        expect_spin();
        press_chk("t3");
        bus.db_in = 1'b0;
        @(negedge clk);
        bus.db_in = 1'b1;
        cyc(11);
        bus.db_in = 1'b0;
        wait_idle("t3");
        check("t3_count", bus.spin_count, 8'(exp_count));
        bus.spin_ack = 1'b0;
        cyc(2);

        // Randomized presses: tied ack or delayed ack, optional ignored re-press.
        for (int i = 0; i < 20; i++) begin
            cyc($urandom_range(2, 6));
            if ($urandom_range(0, 1) == 1) begin
                bus.spin_ack = 1'b1;
                expect_spin();
                press_chk("rnd_tied");
                cyc($urandom_range(0, 3));
                bus.db_in = 1'b0;
                wait_idle("rnd_tied");
                bus.spin_ack = 1'b0;
            end else begin
                bus.spin_ack = 1'b0;
                expect_spin();
                press_chk("rnd_late");
                bus.db_in = 1'b0;
                d = $urandom_range(1, 15);
                if (d >= 6 && $urandom_range(0, 1) == 1) begin
                    cyc(2);
                    bus.db_in = 1'b1;
                    cyc(2);
                    bus.db_in = 1'b0;
                    cyc(d - 4);
                end else begin
                    cyc(d);
                end
                bus.spin_ack = 1'b1;
                @(negedge clk);
                bus.spin_ack = 1'b0;
                check("rnd_req_drop", bus.spin_req, 1'b0);
                wait_idle("rnd_late");
            end
        end
        cyc(2);
        check("rnd_count", bus.spin_count, 8'(exp_count));

        // Asynchronous reset while a request is pending.
        press_chk("t5");
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("t5_req_rst", bus.spin_req, 1'b0);
        check("t5_busy_rst", bus.busy, 1'b0);
        check("t5_count_rst", bus.spin_count, 8'd0);
        exp_count = 0;
        exp_q.delete();
        bus.db_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc(5);

        // 256 spins wrap the counter back to zero.
        bus.spin_ack = 1'b1;
        repeat (256) begin
            expect_spin();
            press_chk("wrap");
            bus.db_in = 1'b0;
            wait_idle("wrap");
            cyc(2);
        end
        check("wrap_count", bus.spin_count, 8'd0);

        // Button held through reset must not fire until released and re-pressed.
        bus.db_in = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        exp_count = 0;
        exp_q.delete();
        cyc(2);
        rst_n = 1'b1;
        hi = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.spin_req || bus.busy) hi++;
        end
        check("t7_no_spin_held", hi, 0);
        bus.db_in = 1'b0;
        cyc(4);
        expect_spin();
        press_chk("t7");
        bus.db_in = 1'b0;
        wait_idle("t7");
        check("t7_count", bus.spin_count, 8'(exp_count));
        cyc(3);

        // Button held with ack tied high.
        n    = 0;
        prev = 0;
`ifdef SPIN_AUTOREPEAT_EN
        expect_spin();
        expect_spin();
        expect_spin();
        bus.db_in = 1'b1;
        for (int c = 0; c < 150; c++) begin
            @(negedge clk);
            if (bus.spin_req && prev == 0) begin
                t[n] = c;
                n++;
            end
            prev = int'(bus.spin_req);
            if (n == 3) break;
        end
        bus.db_in = 1'b0;
        check("ar_rises", n, 3);
        if (n == 3) check("ar_period", t[2] - t[1], 20);
`else
        t[0] = 0;
        expect_spin();
        bus.db_in = 1'b1;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (bus.spin_req && prev == 0) begin
                t[0] = c;
                n++;
            end
            prev = int'(bus.spin_req);
        end
        bus.db_in = 1'b0;
        check("hold_single_spin", n, 1);
        check("hold_latency", t[0], 2);
`endif
        wait_idle("hold");
        bus.spin_ack = 1'b0;
        cyc(4);
        check("hold_count", bus.spin_count, 8'(exp_count));
        check("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
